ysyx_22050854_imm_stage: RTL and testbench
==========================================

# ysyx_22050854_imm_stage

Registered immediate-generation stage for the NPC decode path. It accepts an instruction word, an immediate-type selector and a passthrough tag through a valid/ready handshake. It then emits the sign- or zero-extended immediate one cycle later. A 2-entry skid buffer decouples `in_ready` from downstream backpressure. Compared with the combinational generator, it adds XLEN parametrisation, CSR zimm and shift-amount types, flush support and flow control.

## Interface
- `XLEN`, 64: immediate width. Legal values are 32 and 64.
- `TAG_W`, 64: width of the passthrough tag (PC or ROB id).
- `clk` in 1: clock. Rising edge only.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all buffered entries.
- `in_valid` in 1: upstream has a request.
- `in_ready` out 1: stage can accept a request.
- `in_instr` in 32: raw instruction word.
- `in_extop` in 3: immediate type selector.
- `in_tag` in TAG_W: carried unchanged to the output.
- `out_valid` out 1: output entry is valid.
- `out_ready` in 1: downstream accepts the output entry.
- `out_imm` out XLEN: generated immediate.
- `out_tag` out TAG_W: tag of the output entry.
- `out_illegal` out 1: present only with `YSYX_22050854_IMM_ERR_EN`.

## Operation
- ExtOP encodings:
  - 000 I: sext(instr[31:20]).
  - 001 U: sext({instr[31:12], 12'b0}).
  - 010 S: sext({instr[31:25], instr[11:7]}).
  - 011 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 100 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 101 Z: zext(instr[19:15]).
  - 110 SH: zext(instr[25:20]) when XLEN=64; zext(instr[24:20]) when XLEN=32.
  - 111: reserved, immediate = 0.
- Sign extension always replicates instr[31] up to bit XLEN-1. The immediate is computed at the input and stored with the entry, not recomputed at the output.
- Buffer holds two entries: `main` drives the outputs; `skid` holds an overflow entry.
- State machine (occupancy):
  - EMPTY.
    - Accept → ONE.
  - ONE.
    - Accept without drain → TWO (new entry goes to `skid`).
    - Drain without accept → EMPTY.
    - Accept and drain in the same cycle → ONE (new entry goes to `main`).
  - TWO.
    - Drain → ONE (`skid` moves to `main`).
    - No accept is possible in TWO.
- Handshake signals:
  - Accept = `in_valid && in_ready`.
  - Drain = `out_valid && out_ready`.
  - `in_ready` = !rst && state != TWO.
  - `out_valid` = state != EMPTY.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush or reset.
- `flush`: next state is EMPTY. A request offered in the flush cycle is not stored. It counts as neither an accept nor a drain.
- While `out_valid && !out_ready`, `out_imm` and `out_tag` hold stable.

## Timing
- Latency: an entry accepted at edge N is visible on the outputs after edge N. Throughput is 1 per cycle when `out_ready` is held high.
- `in_ready` depends only on state and `rst`; it has no combinational path from `out_ready`.
- Reset values:
  - State: EMPTY.
  - `out_valid`: 0.
  - `out_imm`: 0.
  - `out_tag`: 0.
  - `out_illegal`: 0.
  - `in_ready`: 0 while `rst` is high, 1 on the first cycle after.
- Reset mid-operation discards all entries. `rst` has priority over `flush`, and `flush` has priority over accept and drain.
- When `out_ready` is deasserted with the stage full, `in_ready` falls on the next cycle. The second in-flight request is already captured in `skid`.

## Configuration
- `YSYX_22050854_IMM_ERR_EN` defined:
  - Adds port `out_illegal`, a per-entry bit set when ExtOP = 111.
  - The bit travels with the entry through `skid` and `main`.
  - Immediate is still 0 for ExtOP = 111.
- Undefined: the port and its storage are absent. ExtOP = 111 silently yields 0.

## Structure
- Package `ysyx_22050854_imm_pkg` holds:
  - ExtOP localparams (`EXT_I` … `EXT_SH`, `EXT_RSV`).
  - Occupancy state encoding (EMPTY/ONE/TWO).
- Sub-module `ysyx_22050854_imm_decode`: combinational XLEN-parametrised extractor (instr, extop → imm, illegal). The stage instantiates it once at the input.

## Test plan
- I-type: `in_instr`=0xFFF00093, ExtOP 000, XLEN=64 → `out_imm`=0xFFFFFFFFFFFFFFFF one cycle after accept, tag echoed.
- B-type: 0xFE000EE3 with ExtOP 011 → 0xFFFFFFFFFFFFFFFC. U-type: 0x80000037 with ExtOP 001 → 0xFFFFFFFF80000000 at XLEN=64 and 0x80000000 at XLEN=32.
- Z/SH types:
  - Instr with [19:15]=11111, ExtOP 101 → 0x1F.
  - Instr [25:20]=0x3F, ExtOP 110 → 0x3F at XLEN=64 and 0x1F at XLEN=32.
- Backpressure:
  - Stimulus: `out_ready`=0, three back-to-back valid requests tagged 1, 2, 3.
  - Required: tags 1 and 2 accepted; `in_ready` low from the cycle after tag 2's accept.
  - Release `out_ready` → outputs 1, 2, 3 in order, with no gaps once tag 3 is accepted.
- Flush with the buffer full and a new request offered → next cycle `out_valid`=0, `in_ready`=1, and the offered request never appears.
- Reset asserted mid-stream with one entry pending → all outputs 0 the cycle after. With `YSYX_22050854_IMM_ERR_EN`, ExtOP 111 → `out_imm`=0 and `out_illegal`=1.

Source files
------------

// File: rtl/ysyx_22050854_imm_pkg.sv
// Shared encodings for the registered immediate stage: ExtOP selectors and skid-buffer occupancy.
package ysyx_22050854_imm_pkg;

   localparam logic [2:0] EXT_I   = 3'b000;
   localparam logic [2:0] EXT_U   = 3'b001;
   localparam logic [2:0] EXT_S   = 3'b010;
   localparam logic [2:0] EXT_B   = 3'b011;
   localparam logic [2:0] EXT_J   = 3'b100;
   localparam logic [2:0] EXT_Z   = 3'b101;
   localparam logic [2:0] EXT_SH  = 3'b110;
   localparam logic [2:0] EXT_RSV = 3'b111;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/ysyx_22050854_imm_decode.sv
// Combinational immediate extractor, XLEN-parametrised (32 or 64); no state, no flow control.
module ysyx_22050854_imm_decode
   import ysyx_22050854_imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      extop,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   logic [63:0] full;
   logic        unused_opcode;

   // opcode bits never contribute to any immediate field
   assign unused_opcode = ^instr[6:0];

   always_comb begin
      full    = 64'd0;
      illegal = 1'b0;
      case (extop)
         EXT_I:  full = {{52{instr[31]}}, instr[31:20]};
         EXT_U:  full = {{32{instr[31]}}, instr[31:12], 12'b0};
         EXT_S:  full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         EXT_B:  full = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         EXT_J:  full = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         EXT_Z:  full = {59'd0, instr[19:15]};
         EXT_SH: full = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
         default: begin
            full    = 64'd0;
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = full[XLEN-1:0];

endmodule

// File: rtl/ysyx_22050854_imm_stage.sv
// Registered immediate stage with 2-entry skid buffer; optional out_illegal via YSYX_22050854_IMM_ERR_EN.
// Latency: 1 cycle accept-to-output; 1 entry/cycle with out_ready high.
// Backpressure: in_ready depends on occupancy and rst only, drops the cycle after the buffer fills.
module ysyx_22050854_imm_stage
   import ysyx_22050854_imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_extop,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
`ifdef YSYX_22050854_IMM_ERR_EN
   output logic             out_illegal,
`endif
   output logic [TAG_W-1:0] out_tag
);

   occ_t             state;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_illegal;
   logic [XLEN-1:0]  main_imm, skid_imm;
   logic [TAG_W-1:0] main_tag, skid_tag;
   logic             acc, drn;
   logic             load_main_new, load_main_skid, load_skid;

   ysyx_22050854_imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (in_instr),
      .extop   (in_extop),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   assign in_ready  = !rst && (state != OCC_TWO);
   assign out_valid = (state != OCC_EMPTY);
   assign acc       = in_valid && in_ready;
   assign drn       = out_valid && out_ready;

   // flush suppresses every data move so a discarded request leaves no trace
   assign load_main_new  = !flush && acc && ((state == OCC_EMPTY) || drn);
   assign load_skid      = !flush && acc && (state == OCC_ONE) && !drn;
   assign load_main_skid = !flush && drn && (state == OCC_TWO);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OCC_EMPTY;
      end else if (flush) begin
         state <= OCC_EMPTY;
      end else begin
         case (state)
            OCC_EMPTY: if (acc) state <= OCC_ONE;
            OCC_ONE: begin
               if (acc && !drn)      state <= OCC_TWO;
               else if (!acc && drn) state <= OCC_EMPTY;
            end
            OCC_TWO:   if (drn) state <= OCC_ONE;
            default:   state <= OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_imm <= '0;
         main_tag <= '0;
         skid_imm <= '0;
         skid_tag <= '0;
      end else begin
         if (load_main_new) begin
            main_imm <= dec_imm;
            main_tag <= in_tag;
         end else if (load_main_skid) begin
            main_imm <= skid_imm;
            main_tag <= skid_tag;
         end
         if (load_skid) begin
            skid_imm <= dec_imm;
            skid_tag <= in_tag;
         end
      end
   end

   assign out_imm = main_imm;
   assign out_tag = main_tag;

`ifdef YSYX_22050854_IMM_ERR_EN
   logic main_ill, skid_ill;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_ill <= 1'b0;
         skid_ill <= 1'b0;
      end else begin
         if (load_main_new)       main_ill <= dec_illegal;
         else if (load_main_skid) main_ill <= skid_ill;
         if (load_skid)           skid_ill <= dec_illegal;
      end
   end

   assign out_illegal = main_ill;
`else
   logic unused_illegal;
   assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_ysyx_22050854_imm_stage.sv
// Scoreboard bench: two stage instances (XLEN 64 and 32) share stimulus; a monitor checks every drained entry.
module tb_ysyx_22050854_imm_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [2:0]  in_extop;
   logic [63:0] in_tag;
   logic        in_ready, out_valid;
   logic [63:0] out_imm, out_tag;
   logic        in_ready32, out_valid32;
   logic [31:0] out_imm32;
   logic [63:0] out_tag32;
`ifdef YSYX_22050854_IMM_ERR_EN
   logic        out_ill, out_ill32;
`endif

   int nchk = 0;
   int nfail = 0;

   typedef struct {
      logic [63:0] imm64;
      logic [31:0] imm32;
      logic [63:0] tag;
      logic        ill;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   ysyx_22050854_imm_stage #(.XLEN(64), .TAG_W(64)) dut (
      .clk (clk), .rst (rst), .flush (flush),
      .in_valid (in_valid), .in_ready (in_ready),
      .in_instr (in_instr), .in_extop (in_extop), .in_tag (in_tag),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_imm (out_imm),
`ifdef YSYX_22050854_IMM_ERR_EN
      .out_illegal (out_ill),
`endif
      .out_tag (out_tag)
   );

   ysyx_22050854_imm_stage #(.XLEN(32), .TAG_W(64)) dut32 (
      .clk (clk), .rst (rst), .flush (flush),
      .in_valid (in_valid), .in_ready (in_ready32),
      .in_instr (in_instr), .in_extop (in_extop), .in_tag (in_tag),
      .out_valid (out_valid32), .out_ready (out_ready),
      .out_imm (out_imm32),
`ifdef YSYX_22050854_IMM_ERR_EN
      .out_illegal (out_ill32),
`endif
      .out_tag (out_tag32)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every drained entry must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst || flush) begin
         q.delete();
      end else if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_output: tag 0x%0h imm 0x%0h with nothing expected", out_tag, out_imm);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("imm64", out_imm, e.imm64);
            chk("tag64", out_tag, e.tag);
            chk("valid32", {63'd0, out_valid32}, 64'd1);
            chk("imm32", {32'd0, out_imm32}, {32'd0, e.imm32});
            chk("tag32", out_tag32, e.tag);
`ifdef YSYX_22050854_IMM_ERR_EN
            chk("illegal64", {63'd0, out_ill}, {63'd0, e.ill});
            chk("illegal32", {63'd0, out_ill32}, {63'd0, e.ill});
`endif
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [2:0] op, input logic [63:0] tag,
                       input logic [63:0] e64, input logic [31:0] e32, input logic eill);
      bit done = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_extop = op;
      in_tag   = tag;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready && !flush && !rst) begin
            q.push_back('{e64, e32, tag, eill});
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         nchk++;
         nfail++;
         $display("FAIL send_timeout: tag 0x%0h not accepted, required acceptance within 50 cycles", tag);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_extop = '0; in_tag = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_imm", out_imm, 64'd0);
      chk("rst_out_tag", out_tag, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;

      // every ExtOP, back-to-back with out_ready high
      send(32'hFFF00093, 3'b000, 64'hA0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      send(32'hFE000EE3, 3'b011, 64'hA1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      send(32'h80000037, 3'b001, 64'hA2, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
      send(32'h00A12423, 3'b010, 64'hA3, 64'h8, 32'h8, 1'b0);
      send(32'hFFDFF06F, 3'b100, 64'hA4, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      send(32'h000F8073, 3'b101, 64'hA5, 64'h1F, 32'h1F, 1'b0);
      send(32'hFFFFFFFF, 3'b101, 64'hA6, 64'h1F, 32'h1F, 1'b0);
      send(32'h03F00013, 3'b110, 64'hA7, 64'h3F, 32'h1F, 1'b0);
      send(32'hFFFFFFFF, 3'b111, 64'hA8, 64'h0, 32'h0, 1'b1);
      idle(3);

      // backpressure: tags 1,2 fill the buffer, tag 3 waits, then drains in order without gaps
      out_ready = 1'b0;
      send(32'hFFF00093, 3'b000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      send(32'h03F00013, 3'b110, 64'd2, 64'h3F, 32'h1F, 1'b0);
      fork
         send(32'h80000037, 3'b001, 64'd3, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
         begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_tag", out_tag, 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
            for (int i = 1; i <= 3; i++) begin
               @(negedge clk);
               chk("bp_no_gap_valid", {63'd0, out_valid}, 64'd1);
               chk("bp_order_tag", out_tag, 64'(i));
            end
         end
      join
      idle(3);

      // flush with buffer full and a request on offer
      out_ready = 1'b0;
      send(32'hFFF00093, 3'b000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      send(32'hFFF00093, 3'b000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      in_valid = 1'b1; in_instr = 32'h000F8073; in_extop = 3'b101; in_tag = 64'd6;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(4);

      // reset mid-stream with one entry pending
      out_ready = 1'b0;
      send(32'hFE000EE3, 3'b011, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_out_imm", out_imm, 64'd0);
      chk("midrst_out_tag", out_tag, 64'd0);
      chk("midrst_out_imm32", {32'd0, out_imm32}, 64'd0);
`ifdef YSYX_22050854_IMM_ERR_EN
      chk("midrst_out_illegal", {63'd0, out_ill}, 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(32'h00A12423, 3'b010, 64'd8, 64'h8, 32'h8, 1'b0);
      idle(4);

      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
